// File: rtl/reg_writeback_ctrl_pkg.sv
// rtl/reg_writeback_ctrl_pkg.sv - shared widths, encodings and types for the register writeback controller
// Purpose: data widths, in_kind and CSR funct3 encodings, FSM states,
//          the buffered entry layout and the CSR read-modify-write helper.
// Ports:   none (package).
package reg_writeback_ctrl_pkg;

    localparam int XLEN           = 32;
    localparam int SYS_REGS_WIDTH = 5;
    localparam int CSR_BASE_WIDTH = 12;

    typedef enum logic [1:0] {
        KIND_GPR  = 2'b00,
        KIND_CSR  = 2'b01,
        KIND_NOWR = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

    // funct3[1:0] of the SYSTEM opcode; funct3[2] only picks the immediate
    // source, which is already resolved upstream into csr_src.
    localparam logic [1:0] CSR_OP_ILLEGAL = 2'b00;
    localparam logic [1:0] CSR_OP_RW      = 2'b01;
    localparam logic [1:0] CSR_OP_RS      = 2'b10;
    localparam logic [1:0] CSR_OP_RC      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CSR_RD = 2'b01,
        ST_CSR_WR = 2'b10
    } state_e;

    typedef struct packed {
        kind_e                     kind;
        logic [SYS_REGS_WIDTH-1:0] rd;
        logic [XLEN-1:0]           result;
        logic [1:0]                csr_op;
        logic [CSR_BASE_WIDTH-1:0] csr_addr;
        logic [XLEN-1:0]           csr_src;
        logic                      src_x0;
    } wb_entry_t;

    function automatic logic [XLEN-1:0] csr_new_value(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] src
    );
        case (op)
            CSR_OP_RW: csr_new_value = src;
            CSR_OP_RS: csr_new_value = old_val | src;
            CSR_OP_RC: csr_new_value = old_val & ~src;
            default:   csr_new_value = old_val;
        endcase
    endfunction

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// rtl/reg_writeback_ctrl_wb_fifo.sv - synchronous FIFO buffering writeback entries
// Purpose: DEPTH-entry synchronous FIFO (DEPTH a power of 2, >= 2) with
//          full/empty flags; a push and a pop in one cycle are allowed when full.
// Ports:   clk, rst_n (sync active-low), push/wdata, pop/rdata (show-ahead head),
//          full, empty.
module reg_writeback_ctrl_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // When full, a push only fits if the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - drives GPR and CSR write ports from buffered completion results
// Purpose: buffers execute/memory results, issues single-cycle GPR writes,
//          sequences CSR read-modify-write, applies halt and x0 suppression.
// Ports:   clk, rst_n, halt; in_* entry handshake; rd_* GPR write port;
//          csr_read_addr/csr_read_data CSR read; csr_wr_en/csr_write_* CSR write;
//          retire pulse; busy.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      halt,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_kind,
    input  logic [SYS_REGS_WIDTH-1:0] in_rd_addr,
    input  logic [XLEN-1:0]           in_result,
    input  logic [2:0]                in_funct3,
    input  logic [CSR_BASE_WIDTH-1:0] in_csr_addr,
    input  logic [XLEN-1:0]           in_csr_src,
    input  logic                      in_src_x0,
    output logic                      rd_wr_en,
    output logic [SYS_REGS_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]           rd_wr_data,
    output logic [CSR_BASE_WIDTH-1:0] csr_read_addr,
    input  logic [XLEN-1:0]           csr_read_data,
    output logic                      csr_wr_en,
    output logic [CSR_BASE_WIDTH-1:0] csr_write_addr,
    output logic [XLEN-1:0]           csr_write_data,
    output logic                      retire,
    output logic                      busy
);

    wb_entry_t in_entry, head;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      unused_funct3_imm;

    // Immediate CSR forms share the register-form datapath.
    assign unused_funct3_imm = in_funct3[2];

    assign in_entry = '{kind: kind_e'(in_kind), rd: in_rd_addr, result: in_result,
                        csr_op: in_funct3[1:0], csr_addr: in_csr_addr,
                        csr_src: in_csr_src, src_x0: in_src_x0};

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    reg_writeback_ctrl_wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (in_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    state_e                    state_q, state_d;
    wb_entry_t                 cur_q, cur_d;
    logic                      rd_wr_en_q, rd_wr_en_d;
    logic [SYS_REGS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]           rd_wr_data_q, rd_wr_data_d;
    logic                      csr_wr_en_q, csr_wr_en_d;
    logic [CSR_BASE_WIDTH-1:0] csr_write_addr_q, csr_write_addr_d;
    logic [XLEN-1:0]           csr_write_data_q, csr_write_data_d;
    logic                      retire_q, retire_d;

    always_comb begin
        state_d          = state_q;
        cur_d            = cur_q;
        fifo_pop         = 1'b0;
        rd_wr_en_d       = 1'b0;
        csr_wr_en_d      = 1'b0;
        retire_d         = 1'b0;
        rd_addr_d        = rd_addr_q;
        rd_wr_data_d     = rd_wr_data_q;
        csr_write_addr_d = csr_write_addr_q;
        csr_write_data_d = csr_write_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!halt && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    case (head.kind)
                        KIND_GPR: begin
                            rd_wr_en_d   = (head.rd != '0);
                            rd_addr_d    = head.rd;
                            rd_wr_data_d = head.result;
                            retire_d     = 1'b1;
                        end
                        KIND_CSR: begin
                            // cur_q.csr_addr drives csr_read_addr during CSR_RD.
                            cur_d   = head;
                            state_d = ST_CSR_RD;
                        end
                        default: retire_d = 1'b1;
                    endcase
                end
            end
            ST_CSR_RD: begin
                // Strobes are registered on the CSR_RD -> CSR_WR edge so they
                // are visible for exactly the CSR_WR cycle.
                if (!halt) begin
                    state_d  = ST_CSR_WR;
                    retire_d = 1'b1;
                    if (cur_q.csr_op != CSR_OP_ILLEGAL) begin
                        rd_wr_en_d       = (cur_q.rd != '0);
                        rd_addr_d        = cur_q.rd;
                        rd_wr_data_d     = csr_read_data;
                        // Set/clear with a zero source must not touch the CSR.
                        csr_wr_en_d      = (cur_q.csr_op == CSR_OP_RW) || !cur_q.src_x0;
                        csr_write_addr_d = cur_q.csr_addr;
                        csr_write_data_d = csr_new_value(cur_q.csr_op, csr_read_data,
                                                         cur_q.csr_src);
                    end
                end
            end
            ST_CSR_WR: begin
                if (!halt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cur_q            <= '0;
            rd_wr_en_q       <= 1'b0;
            rd_addr_q        <= '0;
            rd_wr_data_q     <= '0;
            csr_wr_en_q      <= 1'b0;
            csr_write_addr_q <= '0;
            csr_write_data_q <= '0;
            retire_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            cur_q            <= cur_d;
            rd_wr_en_q       <= rd_wr_en_d;
            rd_addr_q        <= rd_addr_d;
            rd_wr_data_q     <= rd_wr_data_d;
            csr_wr_en_q      <= csr_wr_en_d;
            csr_write_addr_q <= csr_write_addr_d;
            csr_write_data_q <= csr_write_data_d;
            retire_q         <= retire_d;
        end
    end

    assign rd_wr_en       = rd_wr_en_q;
    assign rd_addr        = rd_addr_q;
    assign rd_wr_data     = rd_wr_data_q;
    assign csr_read_addr  = cur_q.csr_addr;
    assign csr_wr_en      = csr_wr_en_q;
    assign csr_write_addr = csr_write_addr_q;
    assign csr_write_data = csr_write_data_q;
    assign retire         = retire_q;
    assign busy           = !fifo_empty || (state_q != ST_IDLE);

endmodule
